// File: rtl/splitter_pkg.sv
// Shared types and defaults for the byte-to-nibble splitter.
// The FSM encoding is fixed at two bits so the debug taps stay stable.
package splitter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

    localparam int DEF_NIB_W = 4;

endpackage

// File: rtl/byte_nibble_splitter_nibble_select.sv
// Combinational nibble picker: chooses the first or second nibble of a byte
// according to the emission phase and the configured ordering.
module nibble_select
    import splitter_pkg::*;
#(
    parameter int NIB_W    = DEF_NIB_W,
    parameter int HI_FIRST = 1
) (
    input  logic [2*NIB_W-1:0] byte_in,
    input  logic               second,
    output logic [NIB_W-1:0]   nib
);

    localparam logic HI_BIT = (HI_FIRST != 0);

    logic take_hi;

    // High-first order takes the upper half in the first phase; low-first inverts that.
    assign take_hi = second ^ HI_BIT;
    assign nib     = take_hi ? byte_in[2*NIB_W-1:NIB_W] : byte_in[NIB_W-1:0];

endmodule

// File: rtl/byte_nibble_splitter.sv
// Splits each accepted byte into two nibbles on a valid/ready output,
// allowing back-to-back bytes at one byte per two cycles, and counts bytes sent.
module byte_nibble_splitter
    import splitter_pkg::*;
#(
    parameter int NIB_W    = DEF_NIB_W,
    parameter int HI_FIRST = 1,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*NIB_W-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [NIB_W-1:0]   out_nib,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic [CNT_W-1:0]   byte_cnt,
    output logic               busy
);

    localparam int BYTE_W = 2 * NIB_W;

    state_t            state_q, state_d;
    logic [BYTE_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NIB_W-1:0]  sel_nib;
    logic              phase;
    logic              in_xfer;
    logic              out_xfer;

    assign phase = (state_q == SECOND);

    nibble_select #(
        .NIB_W   (NIB_W),
        .HI_FIRST(HI_FIRST)
    ) u_sel (
        .byte_in(hold_q),
        .second (phase),
        .nib    (sel_nib)
    );

    // Output decode; in SECOND the ready path is combinational so the next
    // byte can be loaded on the same edge the last nibble leaves.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_nib   = '0;
        case (state_q)
            IDLE: begin
                in_ready = !rst;
            end
            FIRST: begin
                out_valid = 1'b1;
                out_nib   = sel_nib;
            end
            SECOND: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_nib   = sel_nib;
                in_ready  = out_ready && !rst;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    hold_d  = in_data;
                    state_d = FIRST;
                end
            end
            FIRST: begin
                if (out_xfer) begin
                    state_d = SECOND;
                end
            end
            SECOND: begin
                if (out_xfer) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (in_xfer) begin
                        hold_d  = in_data;
                        state_d = FIRST;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    assign byte_cnt = cnt_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_byte_nibble_splitter.sv
// Bench for byte_nibble_splitter: three configurations share one stimulus and
// are checked by directed vectors and a nibble-queue scoreboard.
module tb_byte_nibble_splitter;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       out_ready;

    logic       in_ready_w  [3];
    logic [3:0] out_nib_w   [3];
    logic       out_valid_w [3];
    logic       out_last_w  [3];
    logic       busy_w      [3];
    logic [15:0] cnt0, cnt1;
    logic [1:0]  cnt2;

    int checks = 0;
    int errors = 0;

    byte_nibble_splitter #(.NIB_W(4), .HI_FIRST(1), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_w[0]), .out_nib(out_nib_w[0]), .out_valid(out_valid_w[0]),
        .out_ready(out_ready), .out_last(out_last_w[0]), .byte_cnt(cnt0), .busy(busy_w[0]));

    byte_nibble_splitter #(.NIB_W(4), .HI_FIRST(0), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_w[1]), .out_nib(out_nib_w[1]), .out_valid(out_valid_w[1]),
        .out_ready(out_ready), .out_last(out_last_w[1]), .byte_cnt(cnt1), .busy(busy_w[1]));

    byte_nibble_splitter #(.NIB_W(4), .HI_FIRST(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_w[2]), .out_nib(out_nib_w[2]), .out_valid(out_valid_w[2]),
        .out_ready(out_ready), .out_last(out_last_w[2]), .byte_cnt(cnt2), .busy(busy_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d at %0t: got %0h expected %0h", nm, d, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] get_cnt(input int d);
        if (d == 0) return {16'd0, cnt0};
        if (d == 1) return {16'd0, cnt1};
        return {30'd0, cnt2};
    endfunction

    // Scoreboard: each accepted byte becomes two expected nibbles in a small queue.
    logic [3:0] q_nib  [3][4];
    logic       q_last [3][4];
    int         q_n    [3];
    int         mcnt   [3];
    logic       last_acc0;

    initial begin
        for (int d = 0; d < 3; d++) begin
            q_n[d]  = 0;
            mcnt[d] = 0;
        end
        last_acc0 = 1'b0;
    end

    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 3; d++) begin
                q_n[d]  = 0;
                mcnt[d] = 0;
                chk("rst_in_ready", d, {31'd0, in_ready_w[d]}, 32'd0);
                chk("rst_out_valid", d, {31'd0, out_valid_w[d]}, 32'd0);
            end
            last_acc0 = 1'b0;
        end else begin
            for (int d = 0; d < 3; d++) begin
                logic [31:0] modv;
                logic [3:0]  hi, lo;
                modv = (d == 2) ? 32'd4 : 32'd65536;
                chk("sb_cnt", d, get_cnt(d), mcnt[d] % modv);
                chk("sb_busy", d, {31'd0, busy_w[d]}, {31'd0, q_n[d] != 0});
                chk("sb_valid", d, {31'd0, out_valid_w[d]}, {31'd0, q_n[d] != 0});
                chk("sb_in_ready", d, {31'd0, in_ready_w[d]},
                    {31'd0, (q_n[d] == 0) || (q_n[d] == 1 && out_ready)});
                if (q_n[d] == 0) begin
                    chk("sb_idle_nib", d, {28'd0, out_nib_w[d]}, 32'd0);
                end else begin
                    chk("sb_nib", d, {28'd0, out_nib_w[d]}, {28'd0, q_nib[d][0]});
                    chk("sb_last", d, {31'd0, out_last_w[d]}, {31'd0, q_last[d][0]});
                    if (out_ready) begin
                        if (q_last[d][0]) mcnt[d]++;
                        for (int k = 0; k < 3; k++) begin
                            q_nib[d][k]  = q_nib[d][k+1];
                            q_last[d][k] = q_last[d][k+1];
                        end
                        q_n[d]--;
                    end
                end
                if (in_valid && in_ready_w[d] && q_n[d] <= 2) begin
                    hi = in_data[7:4];
                    lo = in_data[3:0];
                    q_nib[d][q_n[d]]    = (d == 1) ? lo : hi;
                    q_last[d][q_n[d]]   = 1'b0;
                    q_nib[d][q_n[d]+1]  = (d == 1) ? hi : lo;
                    q_last[d][q_n[d]+1] = 1'b1;
                    q_n[d] += 2;
                end
            end
            last_acc0 = in_valid && in_ready_w[0];
        end
    end

    typedef struct {
        logic [7:0] b;
        int         st1;
        int         st2;
        logic [3:0] h1, h2, l1, l2;
        logic [1:0] c2;
    } vec_t;

    vec_t vt[6];

    // One byte through an idle splitter with optional stalls in each phase.
    task automatic xfer(input vec_t v, input int exp_cnt);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = v.b; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i <= v.st1; i++) begin
            chk("first_nib", 0, {28'd0, out_nib_w[0]}, {28'd0, v.h1});
            chk("first_nib", 1, {28'd0, out_nib_w[1]}, {28'd0, v.l1});
            chk("first_last", 0, {31'd0, out_last_w[0]}, 32'd0);
            chk("first_in_ready", 0, {31'd0, in_ready_w[0]}, 32'd0);
            if (i == v.st1) out_ready = 1'b1;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        for (int i = 0; i <= v.st2; i++) begin
            chk("second_nib", 0, {28'd0, out_nib_w[0]}, {28'd0, v.h2});
            chk("second_nib", 1, {28'd0, out_nib_w[1]}, {28'd0, v.l2});
            chk("second_last", 0, {31'd0, out_last_w[0]}, 32'd1);
            if (i == v.st2) out_ready = 1'b1;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        chk("end_busy", 0, {31'd0, busy_w[0]}, 32'd0);
        chk("end_valid", 0, {31'd0, out_valid_w[0]}, 32'd0);
        chk("end_cnt", 0, get_cnt(0), exp_cnt);
        chk("end_cnt_wrap", 2, get_cnt(2), {30'd0, v.c2});
    endtask

    initial begin
        vt[0] = '{b: 8'hA5, st1: 0, st2: 0, h1: 4'hA, h2: 4'h5, l1: 4'h5, l2: 4'hA, c2: 2'd1};
        vt[1] = '{b: 8'hC3, st1: 3, st2: 2, h1: 4'hC, h2: 4'h3, l1: 4'h3, l2: 4'hC, c2: 2'd2};
        vt[2] = '{b: 8'h9E, st1: 0, st2: 0, h1: 4'h9, h2: 4'hE, l1: 4'hE, l2: 4'h9, c2: 2'd3};
        vt[3] = '{b: 8'h12, st1: 1, st2: 0, h1: 4'h1, h2: 4'h2, l1: 4'h2, l2: 4'h1, c2: 2'd0};
        vt[4] = '{b: 8'hFF, st1: 0, st2: 1, h1: 4'hF, h2: 4'hF, l1: 4'hF, l2: 4'hF, c2: 2'd1};
        vt[5] = '{b: 8'h00, st1: 0, st2: 0, h1: 4'h0, h2: 4'h0, l1: 4'h0, l2: 4'h0, c2: 2'd2};

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        #23;
        rst = 1'b0;
        #1;
        chk("reset_in_ready", 0, {31'd0, in_ready_w[0]}, 32'd1);
        chk("reset_busy", 0, {31'd0, busy_w[0]}, 32'd0);
        chk("reset_nib", 0, {28'd0, out_nib_w[0]}, 32'd0);
        chk("reset_cnt", 0, get_cnt(0), 32'd0);

        for (int i = 0; i < 6; i++) xfer(vt[i], i + 1);

        // Back-to-back bytes with no bubbles.
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'h12; out_ready = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            if (c <= 6) begin
                chk("b2b_valid", 0, {31'd0, out_valid_w[0]}, 32'd1);
                chk("b2b_nib", 0, {28'd0, out_nib_w[0]}, c);
                chk("b2b_last", 0, {31'd0, out_last_w[0]}, {31'd0, (c % 2) == 0});
                chk("b2b_in_ready", 0, {31'd0, in_ready_w[0]}, {31'd0, (c % 2) == 0});
            end else begin
                chk("b2b_idle_valid", 0, {31'd0, out_valid_w[0]}, 32'd0);
                chk("b2b_cnt", 0, get_cnt(0), 32'd9);
            end
            if (c == 1) in_data = 8'h34;
            if (c == 3) in_data = 8'h56;
            if (c == 5) in_valid = 1'b0;
        end
        out_ready = 1'b0;

        // Reset while the second nibble is pending.
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'h7B; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid_first", 0, {28'd0, out_nib_w[0]}, 32'h7);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("mid_second", 0, {28'd0, out_nib_w[0]}, 32'hB);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 0, {31'd0, out_valid_w[0]}, 32'd0);
        chk("mid_rst_last", 0, {31'd0, out_last_w[0]}, 32'd0);
        chk("mid_rst_cnt", 0, get_cnt(0), 32'd0);
        chk("mid_rst_in_ready", 0, {31'd0, in_ready_w[0]}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 0, {31'd0, in_ready_w[0]}, 32'd1);
        xfer('{b: 8'h01, st1: 0, st2: 0, h1: 4'h0, h2: 4'h1, l1: 4'h1, l2: 4'h0, c2: 2'd1}, 1);

        // Randomized traffic; the producer holds an unaccepted byte.
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (!(in_valid && !last_acc0)) begin
                in_valid = ($urandom_range(3) != 0);
                in_data  = 8'($urandom);
            end
            out_ready = ($urandom_range(2) != 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("drain_busy", 0, {31'd0, busy_w[0]}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/byte_nibble_splitter.md
Name: byte_nibble_splitter

Overview:
- Sequential inverse of the nibble-pair byte packer: accepts one byte {hi, lo} on a valid/ready input and emits it as two nibbles on a valid/ready output.
- Nibble order is configurable; the default sends the high nibble first.
- Sits between byte-wide producers (switch/register logic) and 4-bit consumers (per-nibble display/hex decode, nibble-serial links).
- Counts completed bytes for status display.

Parameters:
- NIB_W, 4: nibble width; input byte is 2*NIB_W bits.
- HI_FIRST, 1: 1 sends in_data[2*NIB_W-1:NIB_W] first; 0 sends in_data[NIB_W-1:0] first.
- CNT_W, 16: width of byte_cnt.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  2*NIB_W  byte to split, sampled on input handshake.
- in_valid  input  1  producer has a byte.
- in_ready  output  1  splitter accepts a byte this cycle.
- out_nib  output  NIB_W  current nibble.
- out_valid  output  1  out_nib is valid.
- out_ready  input  1  consumer takes out_nib this cycle.
- out_last  output  1  high on the second nibble of a byte.
- byte_cnt  output  CNT_W  bytes fully emitted since reset, wraps.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Handshakes: input transfer is in_valid && in_ready at the clk edge; output transfer is out_valid && out_ready at the clk edge.
- State IDLE:
  - in_ready=1, out_valid=0, out_nib=0, out_last=0.
  - On input transfer: capture in_data into hold_reg, go to FIRST.
- State FIRST:
  - out_valid=1, out_last=0, in_ready=0.
  - out_nib = first nibble of hold_reg, per HI_FIRST.
  - On output transfer: go to SECOND.
- State SECOND:
  - out_valid=1, out_last=1, out_nib = other nibble.
  - in_ready = out_ready. This is a combinational path and is required for back-to-back bytes.
  - On output transfer with in_valid=1: capture the new byte into hold_reg, go to FIRST.
  - On output transfer with in_valid=0: go to IDLE.
  - On any SECOND output transfer: byte_cnt increments.
- Latency: a byte accepted at edge N presents its first nibble from cycle N+1. No combinational path from in_data to out_nib.
- Throughput: sustained 1 byte per 2 cycles with out_ready held high and in_valid high. No idle bubble between bytes.
- Stall: while out_valid=1 and out_ready=0, out_nib, out_last and state hold. hold_reg never changes except on an input transfer.
- out_valid, once asserted, does not drop until its transfer completes.
- byte_cnt wraps from 2^CNT_W-1 to 0 without a flag.
- in_valid while in FIRST is ignored; the producer must hold the byte.
- Reset, asynchronous assert:
  - state=IDLE, hold_reg=0, byte_cnt=0.
  - out_valid=0, out_nib=0, out_last=0, busy=0.
  - in_ready forced 0 while rst=1; it becomes 1 in the first cycle after deassertion.
- Reset mid-byte: the partially emitted byte is dropped, no out_last is issued for it, and byte_cnt is not incremented for it.
- All outputs except in_ready are decoded from registered state and hold_reg only.

Decomposition:
- Shared package splitter_pkg:
  - state typedef {IDLE, FIRST, SECOND}, 2-bit encoding.
  - default NIB_W constant.
- Sub-module nibble_select: purely combinational. It picks the first or second nibble of hold_reg given a phase bit and HI_FIRST. It isolates ordering logic from the FSM and is reusable by display muxing.
- FSM, hold register and counter stay in the top module.

Test Plan:
- Reset then single byte: in_data=8'hA5, one-cycle in_valid, out_ready=1 -> out_nib 4'hA (out_last=0) on the next cycle, then 4'h5 (out_last=1); byte_cnt=1; returns to IDLE with busy=0.
- Back-to-back: 8'h12, 8'h34, 8'h56 with in_valid and out_ready held high -> nibbles 1,2,3,4,5,6 on consecutive cycles; out_last on 2,4,6; in_ready high only on IDLE and SECOND cycles; byte_cnt=3.
- Backpressure: 8'hC3 with out_ready=0 for 3 cycles in FIRST and 2 cycles in SECOND -> out_nib holds 4'hC then 4'h3 stably; in_ready=0 throughout FIRST; exactly one byte counted.
- HI_FIRST=0: 8'h9E -> emits 4'hE then 4'h9 with out_last on 4'h9.
- Reset mid-byte: assert rst asynchronously in SECOND after sending 4'h7 of 8'h7B -> out_valid drops immediately; byte_cnt=0; next byte 8'h01 emits 0,1 cleanly.
- Wrap: CNT_W=2, send 5 bytes -> byte_cnt sequence 1,2,3,0,1.
